// File: rtl/mem_sequencer.sv
// mem_sequencer: sequences single requests onto block_ram, hiding read latency
// and performing the read-modify-write needed by bit-set/bit-clear.
module mem_sequencer #(
  parameter int READ_LATENCY = 2,
  parameter int RAM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [13:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        fault,
  output logic [13:0] ram_address,
  output logic [15:0] ram_data_in,
  input  logic [15:0] ram_data_out,
  output logic        ram_chip_enable,
  output logic        ram_write_enable
);
  typedef enum logic [2:0] {IDLE, READ, MODIFY, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] op_q;
  logic [15:0] mask;
  logic [3:0] cnt;
  logic flt;
  logic oob;
  assign oob = {1'b0, addr} >= 15'(RAM_WORDS);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = oob ? DONE : (op == 2'b01 ? WRITE : READ);
      READ:    if (cnt == 4'd0) state_nx = op_q[1] ? MODIFY : DONE;
      MODIFY:  state_nx = WRITE;
      WRITE:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= 2'b00;
      mask <= 16'h0000;
      cnt <= 4'd0;
      flt <= 1'b0;
      rdata <= 16'h0000;
      ram_address <= 14'h0000;
    end else begin
      if (state == IDLE && req) begin
        op_q <= op;
        mask <= wdata;
        ram_address <= addr;
        cnt <= 4'(READ_LATENCY - 1);
        flt <= oob;
        if (oob) rdata <= 16'hffff;
      end
      if (state == READ) begin
        if (cnt == 4'd0) rdata <= ram_data_out;
        else cnt <= cnt - 4'd1;
      end
    end
  end
  // rdata is stable from the end of READ until DONE, so the modified word is a pure decode
  assign ram_data_in = op_q[1] ? (op_q[0] ? rdata & ~mask : rdata | mask) : mask;
  assign busy = state != IDLE;
  assign ready = state == DONE;
  assign fault = ready & flt;
  assign ram_chip_enable = state == READ || state == WRITE;
  assign ram_write_enable = state == WRITE;
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: drives three sequencers (READ_LATENCY 2, 1, 4) in lockstep,
// each with its own latency-modelled block_ram, and checks directed vectors.
module tb_mem_sequencer;
  logic clk = 1'b0;
  logic [2:0] rst_v = 3'b000;
  logic req = 1'b0;
  logic [1:0] op = 2'b00;
  logic [13:0] addr = 14'h0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata_v [3];
  logic [15:0] din_v [3];
  logic [15:0] dout_v [3];
  logic [13:0] ra_v [3];
  logic ready_v [3];
  logic busy_v [3];
  logic fault_v [3];
  logic ce_v [3];
  logic we_v [3];
  int rl [3] = '{2, 1, 4};
  int vectors = 0;
  int errs = 0;
  int lat [3];
  int nrdy [3];
  logic [15:0] rd [3];
  logic fl [3];
  logic [15:0] cem [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int RL = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic [15:0] mem [0:2047];
    int held;
    initial begin
      held = 0;
      for (int j = 0; j < 2048; j++) mem[j] = 16'h0000;
    end
    always @(posedge clk) begin
      if (ce_v[g] && we_v[g]) mem[ra_v[g][10:0]] <= din_v[g];
      held <= (ce_v[g] && !we_v[g]) ? held + 1 : 0;
    end
    // data_out is garbage until chip_enable has been held READ_LATENCY cycles
    assign dout_v[g] = (ce_v[g] && !we_v[g] && held >= RL - 1) ? mem[ra_v[g][10:0]] : 16'hbad0;
    mem_sequencer #(.READ_LATENCY(RL), .RAM_WORDS(2048)) dut (
      .clk(clk), .reset(rst_v[g]), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .rdata(rdata_v[g]), .ready(ready_v[g]), .busy(busy_v[g]), .fault(fault_v[g]),
      .ram_address(ra_v[g]), .ram_data_in(din_v[g]), .ram_data_out(dout_v[g]),
      .ram_chip_enable(ce_v[g]), .ram_write_enable(we_v[g]));
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic zero_out(input string tag, input int i);
    chk(tag, {busy_v[i], ce_v[i], we_v[i], ready_v[i], fault_v[i], rdata_v[i], ra_v[i], din_v[i]}, 64'h0);
  endtask
  task automatic txn(input logic [1:0] o, input logic [13:0] a, input logic [15:0] w,
                     input int stray, input int kill);
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; nrdy[i] = 0; rd[i] = 16'h0; fl[i] = 1'b0; cem[i] = 16'h0;
    end
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = w;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req = (k == stray);
      if (k == stray) begin op = 2'b01; addr = 14'h0001; wdata = 16'hdead; end
      for (int i = 0; i < 3; i++) begin
        if ((kill == 1 && k == 1) || (kill == 2 && k == rl[i] + 1)) begin
          rst_v[i] = 1'b0;
          #1;
          zero_out("rst_outputs", i);
        end
        if (ready_v[i]) begin
          nrdy[i]++;
          if (lat[i] == 0) begin lat[i] = k; rd[i] = rdata_v[i]; fl[i] = fault_v[i]; end
        end
        if (ce_v[i]) cem[i][k] = 1'b1;
      end
    end
    rst_v = 3'b111;
    @(negedge clk);
  endtask
  // kind: 0 write, 1 read, 2 set/clear, 3 fault
  task automatic res(input string tag, input int kind, input logic [15:0] exp_rd, input logic chk_rd);
    int el;
    logic [15:0] ec;
    for (int i = 0; i < 3; i++) begin
      el = kind == 0 ? 2 : kind == 1 ? rl[i] + 1 : kind == 2 ? rl[i] + 3 : 1;
      ec = kind == 0 ? 16'h2 : kind == 3 ? 16'h0 : 16'(((1 << rl[i]) - 1) << 1);
      if (kind == 2) ec[rl[i] + 2] = 1'b1;
      chk({tag, "_latency"}, 64'(lat[i]), 64'(el));
      chk({tag, "_ready_count"}, 64'(nrdy[i]), 64'd1);
      chk({tag, "_fault"}, 64'(fl[i]), 64'(kind == 3));
      chk({tag, "_chip_enable_cycles"}, 64'(cem[i]), 64'(ec));
      if (chk_rd) chk({tag, "_rdata"}, 64'(rd[i]), 64'(exp_rd));
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) zero_out("reset_state", i);
    rst_v = 3'b111;
    @(negedge clk);
    txn(2'b01, 14'h0005, 16'h1234, 0, 0); res("wr_005", 0, 16'h0, 1'b0);
    txn(2'b00, 14'h0005, 16'h0000, 0, 0); res("rd_005", 1, 16'h1234, 1'b1);
    txn(2'b01, 14'h0010, 16'h00f0, 0, 0); res("wr_010", 0, 16'h0, 1'b0);
    txn(2'b10, 14'h0010, 16'h0f01, 0, 0); res("set", 2, 16'h00f0, 1'b1);
    txn(2'b00, 14'h0010, 16'h0000, 0, 0); res("rd_set", 1, 16'h0ff1, 1'b1);
    txn(2'b11, 14'h0010, 16'h00f0, 0, 0); res("clr", 2, 16'h0ff1, 1'b1);
    txn(2'b00, 14'h0010, 16'h0000, 0, 0); res("rd_clr", 1, 16'h0f01, 1'b1);
    txn(2'b00, 14'h0800, 16'h0000, 0, 0); res("oob", 3, 16'hffff, 1'b1);
    txn(2'b01, 14'h07ff, 16'h5a5a, 0, 0); res("wr_7ff", 0, 16'h0, 1'b0);
    txn(2'b00, 14'h07ff, 16'h0000, 0, 0); res("rd_7ff", 1, 16'h5a5a, 1'b1);
    txn(2'b01, 14'h0001, 16'h1111, 0, 0); res("wr_001", 0, 16'h0, 1'b0);
    txn(2'b00, 14'h0005, 16'h0000, 1, 0); res("stray_req", 1, 16'h1234, 1'b1);
    txn(2'b00, 14'h0001, 16'h0000, 0, 0); res("rd_001", 1, 16'h1111, 1'b1);
    for (int i = 0; i < 3; i++) chk("addr_hold_idle", 64'(ra_v[i]), 64'h0001);
    txn(2'b00, 14'h0005, 16'h0000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("busy_after_read_reset", 64'(busy_v[i]), 64'h0);
      chk("rdata_after_read_reset", 64'(rdata_v[i]), 64'h0);
    end
    txn(2'b10, 14'h0010, 16'hf000, 0, 2);
    for (int i = 0; i < 3; i++) chk("busy_after_rmw_reset", 64'(busy_v[i]), 64'h0);
    txn(2'b00, 14'h0010, 16'h0000, 0, 0); res("rd_after_rmw_reset", 1, 16'h0f01, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Transaction sequencer between the F100-L core's data-memory port and the `block_ram` word store. Accepts one single-cycle request at a time (read, write, set-bits, clear-bits) and drives `block_ram`'s chip_enable/write_enable/address/data_in for exactly as long as the RAM needs. Hides the RAM's fixed read latency and returns a single-cycle `ready` pulse with the read data. Performs the read-modify-write that the core's bit-set/bit-clear instructions need, so the core never drives the RAM directly.

## Interface
- `READ_LATENCY`, default 2: clk cycles that `ram_chip_enable` must be held, with `ram_write_enable`=0, before `ram_data_out` is valid. Legal range 1–15.
- `RAM_WORDS`, default 2048: number of implemented words. Addresses >= RAM_WORDS fault.
- `clk`  in  1: single clock; every register is on its rising edge.
- `reset`  in  1: asynchronous, active-low.
- `req`  in  1: single-cycle request strobe. Sampled only in IDLE.
- `op`  in  2: 00 read, 01 write, 10 set bits (mem |= wdata), 11 clear bits (mem &= ~wdata).
- `addr`  in  14: word address.
- `wdata`  in  16: write data or bit mask.
- `rdata`  out  16: read data. For set/clear it is the pre-modify value.
- `ready`  out  1: one-cycle completion pulse.
- `busy`  out  1: high in every state except IDLE.
- `fault`  out  1: pulses together with `ready` when the address is out of range.
- `ram_address`  out  14: to `block_ram` address.
- `ram_data_in`  out  16: to `block_ram` data_in.
- `ram_data_out`  in  16: from `block_ram` data_out.
- `ram_chip_enable`  out  1: to `block_ram` chip_enable.
- `ram_write_enable`  out  1: to `block_ram` write_enable.

## Operation
- States: IDLE, READ, MODIFY, WRITE, DONE.
- IDLE: when `req`=1, latch `op`, `addr` and `wdata`.
  - If `addr` >= RAM_WORDS: go to DONE with the fault flag set, `rdata`=16'hffff, and no RAM access.
  - Otherwise: op 00/10/11 go to READ; op 01 goes to WRITE.
- READ:
  - `ram_chip_enable`=1, `ram_write_enable`=0.
  - A 4-bit counter is loaded with READ_LATENCY-1 on entry and decrements each cycle.
  - When the counter reaches 0, capture `ram_data_out` into `rdata`.
  - Next state: op 00 → DONE; op 10/11 → MODIFY.
- MODIFY: `ram_chip_enable`=0 for one cycle. Compute `ram_data_in` = rdata|mask (op 10) or rdata&~mask (op 11).
- WRITE:
  - One cycle with `ram_chip_enable`=1 and `ram_write_enable`=1.
  - `ram_data_in` = latched wdata (op 01) or the MODIFY result.
  - Next state: DONE.
- DONE:
  - `ready`=1 for this cycle only; `fault`=1 only if the fault flag is set.
  - Next state: IDLE.
- `req` in any state other than IDLE is ignored and is not queued.
- `ram_address` holds the latched address for the whole transaction and keeps its last value in IDLE.
- `ram_chip_enable`=0 in IDLE and DONE.
- `rdata` holds its value until the next read, set/clear or fault completes. A plain write leaves `rdata` unchanged.
- Address compare is unsigned 14-bit. Bits [13:11] are forwarded unchanged.
- Reset (asynchronous, any state), effective immediately:
  - State → IDLE.
  - `ram_chip_enable`, `ram_write_enable`, `ready`, `fault`, `busy` → 0.
  - `rdata`, `ram_address`, `ram_data_in` → 0.
  - Counter → 0.
  - A set/clear interrupted before WRITE leaves memory unmodified.

## Timing
- Request accepted at edge 0; `busy` is high from cycle 1.
- Read: READ occupies cycles 1..READ_LATENCY. `ready` is in cycle READ_LATENCY+1 (cycle 3 at default), with `rdata` valid in that same cycle.
- Write: WRITE in cycle 1, `ready` in cycle 2.
- Set/clear: READ in cycles 1..READ_LATENCY, MODIFY in cycle READ_LATENCY+1, WRITE in READ_LATENCY+2, `ready` in READ_LATENCY+3 (cycle 5 at default).
- Fault: `ready`+`fault` in cycle 1, and `ram_chip_enable` never rises.
- Back-to-back: the earliest next accept is the cycle after `ready` (IDLE). A `req` coincident with `ready` is dropped.
- No combinational path from `req`/`addr` to any `ram_*` output. All outputs are registered or decoded from state registers.

## Test plan
- Reset values: assert `reset`=0 mid-READ → all outputs 0 in the same cycle (before the next edge); after release, `busy`=0.
- Write then read: write 16'h1234 to 12'h005; `ready` at cycle 2. Read 12'h005 → `rdata`=16'h1234 with `ready` at cycle 3; `ram_chip_enable` high exactly cycles 1–2.
- Set/clear bits:
  - Memory 16'h00f0, op 10 mask 16'h0f01 → `rdata`=16'h00f0, `ready` at cycle 5, re-read 16'h0ff1.
  - Then op 11 mask 16'h00f0 → re-read 16'h0f01.
- Out of range: read 14'h0800 → `ready`=`fault`=1 at cycle 1, `rdata`=16'hffff, `ram_chip_enable` stays 0. Address 14'h07ff reads normally.
- Ignored request: pulse `req` (write 16'hdead to 14'h0001) while a read is busy → no write occurs; 14'h0001 retains its old value; exactly one `ready`.
- Reset mid-RMW: assert reset during MODIFY of op 10 → memory word unchanged on re-read. Repeat with READ_LATENCY=1 and READ_LATENCY=4, checking latencies 2/4 and 5/7.
